rr_enc_arbiter8: RTL

- Round-robin arbiter that shares one 8-way resource (e.g. the 8-to-3 encoder datapath or a shared bus slot) among 8 requesters.
- Produces a registered one-hot grant, the binary index of the granted requester, and a valid flag.
- Optional hold-time limit forces rotation so no requester can starve the others.
- Sits between request sources and the shared encoder/resource; downstream logic consumes gnt_idx directly instead of re-encoding gnt.

---
 rtl/rr_enc_arbiter8.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rr_enc_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant, encoded
// grant index, optional hold-time limit, and a one-cycle dead gap between grants.
module rr_enc_arbiter8 #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout,
  output logic             state_dbg
);

  // Handshake: gnt_valid is high on every cycle a grant is held; there is no
  // ready. The winner keeps the resource while its req bit stays high and
  // releases it by dropping req (or loses it when the hold limit expires).

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam logic [7:0] HCNT_MAX = 8'hFF;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       hcnt_q, hcnt_d;
  logic [N-1:0]     gnt_d;
  logic [IDX_W-1:0] idx_d;
  logic             valid_d;
  logic             timeout_d;

  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] pos;
  logic             any_req;
  logic             hold_expired;

  // Rotating priority scan: walk from the farthest offset down so the
  // requester closest to ptr (offset 0 first) is the last one written.
  always_comb begin
    win     = '0;
    pos     = '0;
    any_req = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = ptr_q + IDX_W'(k);
      if (req[pos]) begin
        win     = pos;
        any_req = 1'b1;
      end
    end
  end

  assign hold_expired = (MAX_HOLD != 0) && (hcnt_q == HOLD_LIM);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hcnt_d    = hcnt_q;
    gnt_d     = gnt;
    idx_d     = gnt_idx;
    valid_d   = gnt_valid;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        hcnt_d  = '0;
        if (enable && any_req) begin
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << win;
          idx_d   = win;
          valid_d = 1'b1;
          hcnt_d  = 8'd1;
          state_d = GRANT;
        end
      end

      GRANT: begin
        if (!req[gnt_idx] || hold_expired) begin
          // Timeout only flags a revocation; a voluntary drop is silent.
          timeout_d = req[gnt_idx];
          ptr_d     = gnt_idx + IDX_W'(1);
          gnt_d     = '0;
          idx_d     = '0;
          valid_d   = 1'b0;
          hcnt_d    = '0;
          state_d   = IDLE;
        end else if (hcnt_q != HCNT_MAX) begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end

      default: begin
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        hcnt_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hcnt_q    <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hcnt_q    <= hcnt_d;
      gnt       <= gnt_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
      timeout   <= timeout_d;
    end
  end

  assign state_dbg = state_q;

endmodule
